// File: rtl/debounce_keys.sv
// debounce_keys: per-key synchronizer plus debounce FSM. Turns N bouncing
// push-button inputs into clean levels and 1-clock press/release pulses.
// Each FSM advances only on the shared sample tick.
//
//   state        | meaning
//   -------------+-----------------------------------------------------
//   IDLE         | key released and stable
//   PRESS_WAIT   | key looks pressed, counting agreeing ticks
//   PRESSED      | key pressed and stable (keys_level = 1)
//   RELEASE_WAIT | key looks released, counting agreeing ticks
module debounce_keys #(
    parameter int N            = 4,
    parameter int STABLE_TICKS = 3,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         tick,
    input  logic [N-1:0] keys_raw,
    output logic [N-1:0] keys_level,
    output logic [N-1:0] keys_press,
    output logic [N-1:0] keys_release
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    localparam logic [3:0]   CNT_LAST     = 4'(STABLE_TICKS - 1);
    localparam logic [N-1:0] RELEASED_RAW = {N{ACTIVE_LOW}};

    logic [N-1:0] sync1;
    logic [N-1:0] sync2;
    logic [N-1:0] s;

    state_t       state_q [N];
    state_t       state_d [N];
    logic [3:0]   cnt_q   [N];
    logic [3:0]   cnt_d   [N];
    logic [N-1:0] level_d;
    logic [N-1:0] press_d;
    logic [N-1:0] release_d;

    // Two-flop synchronizer; reset loads the released level so nothing looks pressed.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1 <= RELEASED_RAW;
            sync2 <= RELEASED_RAW;
        end else begin
            sync1 <= keys_raw;
            sync2 <= sync1;
        end
    end

    // Normalise polarity: s = 1 means pressed.
    assign s = sync2 ^ RELEASED_RAW;

    // Next-state logic for all keys; nothing moves on cycles without a tick.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            state_d[i]   = state_q[i];
            cnt_d[i]     = cnt_q[i];
            level_d[i]   = keys_level[i];
            press_d[i]   = 1'b0;
            release_d[i] = 1'b0;
            if (tick) begin
                case (state_q[i])
                    IDLE: begin
                        if (s[i]) begin
                            state_d[i] = PRESS_WAIT;
                            cnt_d[i]   = 4'd1;
                        end
                    end
                    PRESS_WAIT: begin
                        if (!s[i]) begin
                            state_d[i] = IDLE;
                            cnt_d[i]   = 4'd0;
                        end else if (cnt_q[i] == CNT_LAST) begin
                            state_d[i] = PRESSED;
                            cnt_d[i]   = 4'd0;
                            level_d[i] = 1'b1;
                            press_d[i] = 1'b1;
                        end else begin
                            cnt_d[i] = cnt_q[i] + 4'd1;
                        end
                    end
                    PRESSED: begin
                        if (!s[i]) begin
                            state_d[i] = RELEASE_WAIT;
                            cnt_d[i]   = 4'd1;
                        end
                    end
                    RELEASE_WAIT: begin
                        if (s[i]) begin
                            state_d[i] = PRESSED;
                            cnt_d[i]   = 4'd0;
                        end else if (cnt_q[i] == CNT_LAST) begin
                            state_d[i]   = IDLE;
                            cnt_d[i]     = 4'd0;
                            level_d[i]   = 1'b0;
                            release_d[i] = 1'b1;
                        end else begin
                            cnt_d[i] = cnt_q[i] + 4'd1;
                        end
                    end
                    default: begin
                        state_d[i] = IDLE;
                        cnt_d[i]   = 4'd0;
                    end
                endcase
            end
        end
    end

    // State, counters and registered outputs; reset discards all progress.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= 4'd0;
            end
            keys_level   <= '0;
            keys_press   <= '0;
            keys_release <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            keys_level   <= level_d;
            keys_press   <= press_d;
            keys_release <= release_d;
        end
    end

endmodule

// File: tb/tb_debounce_keys.sv
// Bench for debounce_keys: directed scenarios plus random key activity, all
// compared every clock against a run-length reference model.
module tb_debounce_keys;

    localparam int N  = 4;
    localparam int ST = 3;

    logic         clock = 1'b0;
    logic         reset;
    logic         tick;
    logic [N-1:0] keys_raw;
    logic [N-1:0] keys_level;
    logic [N-1:0] keys_press;
    logic [N-1:0] keys_release;

    debounce_keys #(.N(N), .STABLE_TICKS(ST), .ACTIVE_LOW(1'b1)) dut (
        .clock        (clock),
        .reset        (reset),
        .tick         (tick),
        .keys_raw     (keys_raw),
        .keys_level   (keys_level),
        .keys_press   (keys_press),
        .keys_release (keys_release)
    );

    always #10 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit fast   = 1'b0;

    // Reference model: raw delayed two clocks, and for each key the number of
    // consecutive ticks on which the pressed-view disagrees with the level.
    logic [N-1:0] m_s1, m_s2, m_level, m_press, m_release;
    int           m_run [N];

    int press_cnt   [N];
    int release_cnt [N];
    int ticks_seen;
    bit both_seen;

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        for (int i = 0; i < N; i++) begin
            press_cnt[i]   = 0;
            release_cnt[i] = 0;
        end
        both_seen = 1'b0;
    endtask

    task automatic step(input bit rst);
        logic p;
        reset = rst;
        tick  = fast || (cyc % 10 == 9);
        @(posedge clock);
        cyc++;
        if (rst) begin
            m_s1      = '1;
            m_s2      = '1;
            m_level   = '0;
            m_press   = '0;
            m_release = '0;
            for (int i = 0; i < N; i++) m_run[i] = 0;
        end else begin
            m_press   = '0;
            m_release = '0;
            if (tick) begin
                ticks_seen++;
                for (int i = 0; i < N; i++) begin
                    p = ~m_s2[i];
                    if (p != m_level[i]) begin
                        m_run[i]++;
                        if (m_run[i] == ST) begin
                            m_level[i] = p;
                            if (p) m_press[i] = 1'b1;
                            else   m_release[i] = 1'b1;
                            m_run[i] = 0;
                        end
                    end else begin
                        m_run[i] = 0;
                    end
                end
            end
            m_s2 = m_s1;
            m_s1 = keys_raw;
        end
        #1;
        chk("level", keys_level, m_level);
        chk("press", keys_press, m_press);
        chk("release", keys_release, m_release);
        chk("press_and_release_overlap", keys_press & keys_release, '0);
        for (int i = 0; i < N; i++) begin
            if (keys_press[i] === 1'b1)   press_cnt[i]++;
            if (keys_release[i] === 1'b1) release_cnt[i]++;
        end
        if (keys_press[0] === 1'b1 && keys_press[3] === 1'b1) both_seen = 1'b1;
    endtask

    task automatic run_n(input int n);
        for (int k = 0; k < n; k++) step(1'b0);
    endtask

    task automatic align10();
        while (cyc % 10 != 0) step(1'b0);
    endtask

    int first_tick;

    initial begin
        keys_raw = '1;
        reset    = 1'b1;
        tick     = 1'b0;
        clear_counts();
        ticks_seen = 0;

        // Reset with all keys released, then idle.
        for (int k = 0; k < 3; k++) step(1'b1);
        chk("reset_level", keys_level, '0);
        run_n(50);
        chk_int("idle_no_press", press_cnt[0] + press_cnt[1] + press_cnt[2] + press_cnt[3], 0);
        chk_int("idle_no_release", release_cnt[0] + release_cnt[1] + release_cnt[2] + release_cnt[3], 0);

        // Key 0 pressed and held: one press pulse only.
        clear_counts();
        keys_raw[0] = 1'b0;
        run_n(200);
        chk_int("hold_press0_count", press_cnt[0], 1);
        chk("hold_level0", {3'b000, keys_level[0]}, 4'b0001);

        // Key 1 bounces once per tick for six ticks, then settles pressed.
        clear_counts();
        align10();
        for (int k = 0; k < 60; k++) begin
            if (k % 10 == 0) keys_raw[1] = ~keys_raw[1];
            step(1'b0);
        end
        chk_int("bounce_press1_count", press_cnt[1], 0);
        keys_raw[1] = 1'b0;
        run_n(60);
        chk_int("settled_press1_count", press_cnt[1], 1);

        // Key 0 released cleanly.
        clear_counts();
        keys_raw[0] = 1'b1;
        run_n(60);
        chk_int("release0_count", release_cnt[0], 1);
        chk("release_level0", {3'b000, keys_level[0]}, 4'b0000);

        // Key 0 re-pressed, then a one-tick release glitch.
        keys_raw[0] = 1'b0;
        run_n(60);
        clear_counts();
        keys_raw[0] = 1'b1;
        run_n(10);
        keys_raw[0] = 1'b0;
        run_n(50);
        chk_int("glitch_release0_count", release_cnt[0], 0);
        chk("glitch_level0", {3'b000, keys_level[0]}, 4'b0001);

        // Release everything, then keys 0 and 3 fall on the same clock.
        keys_raw = '1;
        run_n(60);
        clear_counts();
        keys_raw[0] = 1'b0;
        keys_raw[3] = 1'b0;
        run_n(50);
        chk_int("simul_press0", press_cnt[0], 1);
        chk_int("simul_press3", press_cnt[3], 1);
        chk_int("simul_same_cycle", int'(both_seen), 1);

        // Reset during key 2 PRESS_WAIT; press needs three fresh ticks after reset.
        keys_raw = '1;
        run_n(60);
        align10();
        clear_counts();
        keys_raw[2] = 1'b0;
        run_n(20);
        chk_int("prereset_press2", press_cnt[2], 0);
        for (int k = 0; k < 3; k++) begin
            step(1'b1);
            chk("in_reset_level", keys_level, '0);
            chk("in_reset_press", keys_press, '0);
        end
        ticks_seen = 0;
        first_tick = -1;
        for (int k = 0; k < 80; k++) begin
            step(1'b0);
            if (keys_press[2] === 1'b1 && first_tick < 0) first_tick = ticks_seen;
        end
        chk_int("postreset_press2_tick", first_tick, 3);
        chk_int("postreset_press2_count", press_cnt[2], 1);

        // Random activity with the 1-in-10 tick, then with tick held high.
        for (int k = 0; k < 800; k++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 19) == 0) keys_raw[i] = ~keys_raw[i];
            step(1'b0);
        end
        fast = 1'b1;
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 3) == 0) keys_raw[i] = ~keys_raw[i];
            step(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
